// File: rtl/cpu_clk_switch_pkg.sv
// Shared definitions for the 65816 PHI2 clock switch.
//   - clk_state_e  : clock FSM state encoding
//   - Map*         : bit positions of the clock-control field in the map register,
//                    shared with the address-mapping stage
//   - HalfDiv*     : fast half-period lengths in hsclk cycles
//   - half_period(): map clock bits -> fast half-period
package cpu_clk_switch_pkg;

    typedef enum logic [1:0] {
        StAlign  = 2'd0,
        StHostHi = 2'd1,
        StLow    = 2'd2,
        StFastHi = 2'd3
    } clk_state_e;

    localparam int unsigned MapHsclkEn  = 3;
    localparam int unsigned MapHsclkInv = 2;
    localparam int unsigned MapDivEn    = 1;
    localparam int unsigned MapDiv4Not2 = 0;

    localparam int unsigned HalfDiv1 = 1;
    localparam int unsigned HalfDiv2 = 2;
    localparam int unsigned HalfDiv4 = 4;

    function automatic int unsigned half_period(input logic div_en, input logic div4not2);
        if (!div_en) begin
            return HalfDiv1;
        end else if (div4not2) begin
            return HalfDiv4;
        end else begin
            return HalfDiv2;
        end
    endfunction

endpackage

// File: rtl/cpu_clk_switch_phi0_sync.sv
// Brings host PHI0 into the hsclk domain and produces one-cycle edge pulses.
// Ports:
//   hsclk      in   fast clock
//   resetb     in   async active-low reset
//   phi0_in    in   host PHI0, asynchronous to hsclk
//   phi0_rise  out  one-hsclk pulse after a synced rising edge
//   phi0_fall  out  one-hsclk pulse after a synced falling edge
// SYNC_STAGES must be at least 2. Both edges see the same latency.
module cpu_clk_switch_phi0_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic hsclk,
    input  logic resetb,
    input  logic phi0_in,
    output logic phi0_rise,
    output logic phi0_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], phi0_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to all ones: a PHI0 already high at reset release must not look like a
    // fresh rising edge, otherwise the first CPU phase could join a host phi2 mid-way.
    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign phi0_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign phi0_fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/cpu_clk_switch.sv
// 65816 PHI2 generator: runs the CPU from divided hsclk during fast cycles and hands
// it back to the host 2 MHz PHI0 for any cycle flagged as a host-bus access.
// Ports:
//   hsclk            in   fast oscillator; all state lives here
//   resetb           in   async active-low reset
//   bbc_ck2_phi0     in   host PHI0 (asynchronous)
//   hsclk_en         in   map bit 3: permit fast cycles
//   hsclk_inv        in   map bit 2: one extra hsclk before a host-timed high phase
//   div_en           in   map bit 1: divide fast clock
//   div4not2         in   map bit 0: deeper division when div_en=1
//   host_access_req  in   current cycle targets host bus (valid by end of phi1)
//   cpu_ck_phi2      out  registered CPU clock
//   cpu_ck_phi1      out  inverse of cpu_ck_phi2
//   host_cycle       out  in ALIGN or HOST_HI
//   fast_cycle       out  in FAST_HI
module cpu_clk_switch
    import cpu_clk_switch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned MIN_PH1_CYCLES = 2,
    parameter int unsigned CNT_W          = 3
) (
    input  logic hsclk,
    input  logic resetb,
    input  logic bbc_ck2_phi0,
    input  logic hsclk_en,
    input  logic hsclk_inv,
    input  logic div_en,
    input  logic div4not2,
    input  logic host_access_req,
    output logic cpu_ck_phi2,
    output logic cpu_ck_phi1,
    output logic host_cycle,
    output logic fast_cycle
);

    // One extra bit so a half-period of exactly 2^CNT_W is representable.
    localparam int unsigned HW = CNT_W + 1;

    logic             phi0_rise, phi0_fall;
    logic [3:0]       map_bits;
    clk_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [HW-1:0]    h_q, h_d, h_map, low_last, fast_last, cnt_ext;
    logic             inv_pend_q, inv_pend_d;
    logic             phi2_q, phi2_d;

    cpu_clk_switch_phi0_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_phi0_sync (
        .hsclk    (hsclk),
        .resetb   (resetb),
        .phi0_in  (bbc_ck2_phi0),
        .phi0_rise(phi0_rise),
        .phi0_fall(phi0_fall)
    );

    always_comb begin
        map_bits              = '0;
        map_bits[MapHsclkEn]  = hsclk_en;
        map_bits[MapHsclkInv] = hsclk_inv;
        map_bits[MapDivEn]    = div_en;
        map_bits[MapDiv4Not2] = div4not2;
    end

    always_comb begin
        h_map     = HW'(half_period(map_bits[MapDivEn], map_bits[MapDiv4Not2]));
        // Low phase never shorter than the address/decode settle time.
        low_last  = ((h_q > HW'(MIN_PH1_CYCLES)) ? h_q : HW'(MIN_PH1_CYCLES)) - HW'(1);
        fast_last = h_q - HW'(1);
        cnt_ext   = {1'b0, cnt_q};
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_d        = h_q;
        inv_pend_d = 1'b0;
        unique case (state_q)
            StAlign: begin
                // Only a fresh rise counts; a fall here is ignored.
                if (inv_pend_q) begin
                    state_d = StHostHi;
                end else if (phi0_rise) begin
                    if (map_bits[MapHsclkInv]) begin
                        inv_pend_d = 1'b1;
                    end else begin
                        state_d = StHostHi;
                    end
                end
            end
            StHostHi: begin
                if (phi0_fall) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    h_d     = h_map;
                end
            end
            StLow: begin
                cnt_d = cnt_inc;
                if (cnt_ext == low_last) begin
                    if (host_access_req || !map_bits[MapHsclkEn]) begin
                        state_d = StAlign;
                    end else begin
                        state_d = StFastHi;
                        cnt_d   = '0;
                    end
                end
            end
            StFastHi: begin
                cnt_d = cnt_inc;
                if (cnt_ext == fast_last) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    h_d     = h_map;
                end
            end
            default: state_d = StAlign;
        endcase
        phi2_d = (state_d == StHostHi) || (state_d == StFastHi);
    end

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= StAlign;
            cnt_q      <= '0;
            h_q        <= HW'(HalfDiv1);
            inv_pend_q <= 1'b0;
            phi2_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_q        <= h_d;
            inv_pend_q <= inv_pend_d;
            phi2_q     <= phi2_d;
        end
    end

    assign cpu_ck_phi2 = phi2_q;
    assign cpu_ck_phi1 = ~phi2_q;
    assign host_cycle  = (state_q == StAlign) || (state_q == StHostHi);
    assign fast_cycle  = (state_q == StFastHi);

endmodule

// File: tb/tb_cpu_clk_switch.sv
`timescale 1ns / 1ps
// Bench for cpu_clk_switch: directed phases plus randomized map/request traffic,
// checked every hsclk against a phase-level behavioural model.
module tb_cpu_clk_switch;

    logic hsclk = 1'b0;
    logic resetb = 1'b0;
    logic bbc_ck2_phi0 = 1'b0;
    logic hsclk_en = 1'b0;
    logic hsclk_inv = 1'b0;
    logic div_en = 1'b0;
    logic div4not2 = 1'b0;
    logic host_access_req = 1'b0;
    logic cpu_ck_phi2, cpu_ck_phi1, host_cycle, fast_cycle;

    int checks = 0;
    int errors = 0;

    cpu_clk_switch u_dut (
        .hsclk          (hsclk),
        .resetb         (resetb),
        .bbc_ck2_phi0   (bbc_ck2_phi0),
        .hsclk_en       (hsclk_en),
        .hsclk_inv      (hsclk_inv),
        .div_en         (div_en),
        .div4not2       (div4not2),
        .host_access_req(host_access_req),
        .cpu_ck_phi2    (cpu_ck_phi2),
        .cpu_ck_phi1    (cpu_ck_phi1),
        .host_cycle     (host_cycle),
        .fast_cycle     (fast_cycle)
    );

    // 32 MHz hsclk; 2 MHz PHI0 with edges 7 ns after an hsclk rising edge.
    always #15.625 hsclk = ~hsclk;
    initial begin
        #22.625;
        forever begin
            bbc_ck2_phi0 = ~bbc_ck2_phi0;
            #250;
        end
    end

    // ---------------- behavioural model ----------------
    // The CPU clock acts on a host PHI0 edge 3 hsclk after it happens. During reset
    // PHI0 is treated as high so only a genuine rise after reset can start a phase.
    logic exp_clk = 1'b0, exp_host = 1'b1, exp_fast = 1'b0;
    bit   samp[$];
    bit   rise_now, fall_now, aborted;

    function automatic int half_of(input logic den, input logic d4);
        if (!den) return 1;
        return d4 ? 4 : 2;
    endfunction

    task automatic set_exp(input logic c, input logic h, input logic f);
        exp_clk  = c;
        exp_host = h;
        exp_fast = f;
    endtask

    task automatic tick();
        @(posedge hsclk);
        samp.push_back(resetb ? bbc_ck2_phi0 : 1'b1);
        if (samp.size() > 8) void'(samp.pop_front());
        rise_now = samp[$-2] && !samp[$-3];
        fall_now = !samp[$-2] && samp[$-3];
        if (!resetb) aborted = 1'b1;
    endtask

    task automatic run_phases();
        int h;
        int n;
        forever begin
            set_exp(1'b0, 1'b1, 1'b0);
            do begin
                tick();
                if (aborted) return;
            end while (!rise_now);
            if (hsclk_inv) begin
                tick();
                if (aborted) return;
            end
            set_exp(1'b1, 1'b1, 1'b0);
            do begin
                tick();
                if (aborted) return;
            end while (!fall_now);
            h = half_of(div_en, div4not2);
            set_exp(1'b0, 1'b0, 1'b0);
            forever begin
                n = (h > 2) ? h : 2;
                repeat (n) begin
                    tick();
                    if (aborted) return;
                end
                if (host_access_req || !hsclk_en) break;
                set_exp(1'b1, 1'b0, 1'b1);
                repeat (h) begin
                    tick();
                    if (aborted) return;
                end
                h = half_of(div_en, div4not2);
                set_exp(1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        repeat (4) samp.push_back(1'b1);
        forever begin
            set_exp(1'b0, 1'b1, 1'b0);
            do tick(); while (!resetb);
            aborted = 1'b0;
            run_phases();
        end
    end

    // ---------------- checking ----------------
    task automatic check_outputs();
        logic e_clk, e_host, e_fast;
        if (!resetb) begin
            e_clk = 1'b0; e_host = 1'b1; e_fast = 1'b0;
        end else begin
            e_clk = exp_clk; e_host = exp_host; e_fast = exp_fast;
        end
        checks++;
        assert (cpu_ck_phi2 === e_clk) else begin
            errors++;
            $error("FAIL phi2 got=%b want=%b t=%0t", cpu_ck_phi2, e_clk, $time);
        end
        checks++;
        assert (cpu_ck_phi1 === ~e_clk) else begin
            errors++;
            $error("FAIL phi1 got=%b want=%b t=%0t", cpu_ck_phi1, ~e_clk, $time);
        end
        checks++;
        assert (host_cycle === e_host) else begin
            errors++;
            $error("FAIL host_cycle got=%b want=%b t=%0t", host_cycle, e_host, $time);
        end
        checks++;
        assert (fast_cycle === e_fast) else begin
            errors++;
            $error("FAIL fast_cycle got=%b want=%b t=%0t", fast_cycle, e_fast, $time);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge hsclk);
            check_outputs();
        end
    endtask

    task automatic wait_fast(input string tag);
        for (int i = 0; i < 200 && !fast_cycle; i++) run_cycles(1);
        checks++;
        assert (fast_cycle === 1'b1) else begin
            errors++;
            $error("FAIL %s timeout got=%b want=1", tag, fast_cycle);
        end
    endtask

    task automatic set_map(input logic [3:0] m);
        hsclk_en  = m[3];
        hsclk_inv = m[2];
        div_en    = m[1];
        div4not2  = m[0];
    endtask

    initial begin
        // Boot: 1 us reset, host-only clocking afterwards.
        set_map(4'b0000);
        run_cycles(32);
        #2 resetb = 1'b1;
        run_cycles(200);

        // Fast divide ratios.
        set_map(4'b1000); run_cycles(150);
        set_map(4'b1010); run_cycles(150);
        set_map(4'b1011); run_cycles(150);

        // Fast -> host -> fast.
        set_map(4'b1000);
        host_access_req = 1'b1; run_cycles(60);
        host_access_req = 1'b0; run_cycles(100);

        // Host phase with the extra hsclk delay.
        set_map(4'b1100);
        host_access_req = 1'b1; run_cycles(100);
        host_access_req = 1'b0; run_cycles(50);
        set_map(4'b1000);

        // Map change during a H=4 high phase.
        set_map(4'b1011); run_cycles(40);
        wait_fast("fast_h4");
        set_map(4'b1000); run_cycles(60);

        // Async reset during FAST_HI.
        wait_fast("fast_rst");
        #2 resetb = 1'b0;
        #1;
        checks++;
        assert (cpu_ck_phi2 === 1'b0) else begin
            errors++;
            $error("FAIL async_rst_phi2 got=%b want=0", cpu_ck_phi2);
        end
        checks++;
        assert (host_cycle === 1'b1) else begin
            errors++;
            $error("FAIL async_rst_host got=%b want=1", host_cycle);
        end
        run_cycles(8);
        #2 resetb = 1'b1;
        run_cycles(100);

        // Randomized map bits and request bursts.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) host_access_req = ~host_access_req;
            if ($urandom_range(0, 99) == 0) begin
                set_map(4'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) != 0) hsclk_en = 1'b1;
            end
            run_cycles(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
